// File: rtl/register_bank_sb.sv
// register_bank_sb
//   Register file for the decode/writeback stage: NUM_RD combinational read
//   ports, one write port with unconditional and conditional (multiply-unit /
//   movn) modes, optional same-cycle write-to-read forwarding, a per-register
//   busy scoreboard for multi-cycle producers, and a debug read port.
//
// Parameters
//   DATA_W  register width in bits
//   ADDR_W  register address width, depth = 2**ADDR_W
//   NUM_RD  number of read ports (1..4)
//   BYPASS  1 = committing write data forwarded to matching read ports
//
// Ports
//   clock             system clock, rising edge
//   reset             synchronous, active-high; clears data, busy and count
//   rd_addr           read addresses, port k at [k*ADDR_W +: ADDR_W]
//   rd_data           read data, port k at [k*DATA_W +: DATA_W]
//   rd_busy           busy bit of each addressed register
//   write_enable      00 off, 01 write, 10 conditional write, 11 no-op
//   write_reg         write address
//   write_data        write data
//   muu_write_enable  condition A for conditional write
//   movn              condition B for conditional write
//   issue_valid       mark issue_reg busy
//   issue_reg         register to mark busy
//   dbg_addr          debug read address
//   dbg_data          debug read data, never forwarded
//   write_count       committed writes, saturating at 16'hFFFF

module register_bank_sb #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NUM_RD = 2,
    parameter int BYPASS = 1
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
    output logic [NUM_RD*DATA_W-1:0]   rd_data,
    output logic [NUM_RD-1:0]          rd_busy,
    input  logic [1:0]                 write_enable,
    input  logic [ADDR_W-1:0]          write_reg,
    input  logic [DATA_W-1:0]          write_data,
    input  logic                       muu_write_enable,
    input  logic                       movn,
    input  logic                       issue_valid,
    input  logic [ADDR_W-1:0]          issue_reg,
    input  logic [ADDR_W-1:0]          dbg_addr,
    output logic [DATA_W-1:0]          dbg_data,
    output logic [15:0]                write_count
);

    localparam int DEPTH     = 1 << ADDR_W;
    localparam bit BYPASS_ON = (BYPASS != 0);

    logic [DATA_W-1:0] regs [DEPTH];
    logic [DEPTH-1:0]  busy;
    logic [15:0]       write_count_q;

    logic mode_commits;
    logic we_eff;
    logic retire;

    // A write commits in mode 01, or in mode 10 when either condition holds.
    // Register 0 is hardwired, so it never commits.
    assign mode_commits = (write_enable == 2'b01) ||
                          ((write_enable == 2'b10) && (muu_write_enable || movn));
    assign we_eff       = mode_commits && (write_reg != '0);

    // Any writeback attempt (mode 01 or 10) means the producer has retired,
    // even when a conditional write does not commit its data.
    assign retire = ((write_enable == 2'b01) || (write_enable == 2'b10)) &&
                    (write_reg != '0);

    // Data storage and commit counter. Reset wins over any write.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
            write_count_q <= '0;
        end else if (we_eff) begin
            regs[write_reg] <= write_data;
            if (write_count_q != 16'hFFFF) begin
                write_count_q <= write_count_q + 16'd1;
            end
        end
    end

    // Scoreboard. The issue assignment comes last so that a same-cycle
    // issue and retire on one register leaves it busy.
    always_ff @(posedge clock) begin
        if (reset) begin
            busy <= '0;
        end else begin
            if (retire) begin
                busy[write_reg] <= 1'b0;
            end
            if (issue_valid && (issue_reg != '0)) begin
                busy[issue_reg] <= 1'b1;
            end
        end
    end

    // Read ports: stored value, optionally overridden by the committing
    // write. Busy is always the registered state.
    always_comb begin
        rd_data = '0;
        rd_busy = '0;
        for (int k = 0; k < NUM_RD; k++) begin
            logic [ADDR_W-1:0] a;
            a = rd_addr[k*ADDR_W +: ADDR_W];
            if (a == '0) begin
                rd_data[k*DATA_W +: DATA_W] = '0;
            end else if (BYPASS_ON && we_eff && (a == write_reg)) begin
                rd_data[k*DATA_W +: DATA_W] = write_data;
            end else begin
                rd_data[k*DATA_W +: DATA_W] = regs[a];
            end
            rd_busy[k] = busy[a];
        end
    end

    assign dbg_data    = (dbg_addr == '0) ? '0 : regs[dbg_addr];
    assign write_count = write_count_q;

endmodule

// File: tb/tb_register_bank_sb.sv
// tb_register_bank_sb
//   Directed bench for register_bank_sb. A BYPASS=1 and a BYPASS=0 instance
//   share every input. Stimulus pushes expected values tagged with the
//   current cycle into a queue; a monitor on the falling edge pops and
//   compares them against the outputs.

module tb_register_bank_sb;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NR = 2;

    localparam int K_RD0  = 0;
    localparam int K_RD1  = 1;
    localparam int K_DBG  = 2;
    localparam int K_BSY0 = 3;
    localparam int K_BSY1 = 4;
    localparam int K_WC   = 5;
    localparam int K_NB0  = 6;

    logic              clock = 1'b0;
    logic              reset;
    logic [AW-1:0]     rd_addr0, rd_addr1;
    logic [NR*AW-1:0]  rd_addr;
    logic [NR*DW-1:0]  rd_data, nb_rd_data;
    logic [NR-1:0]     rd_busy, nb_rd_busy;
    logic [1:0]        write_enable;
    logic [AW-1:0]     write_reg;
    logic [DW-1:0]     write_data;
    logic              muu_write_enable, movn, issue_valid;
    logic [AW-1:0]     issue_reg, dbg_addr;
    logic [DW-1:0]     dbg_data, nb_dbg_data;
    logic [15:0]       write_count, nb_write_count;

    assign rd_addr = {rd_addr1, rd_addr0};

    register_bank_sb #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .BYPASS(1)) dut (
        .clock(clock), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data),
        .rd_busy(rd_busy), .write_enable(write_enable), .write_reg(write_reg),
        .write_data(write_data), .muu_write_enable(muu_write_enable),
        .movn(movn), .issue_valid(issue_valid), .issue_reg(issue_reg),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data), .write_count(write_count)
    );

    register_bank_sb #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .BYPASS(0)) dut_nb (
        .clock(clock), .reset(reset), .rd_addr(rd_addr), .rd_data(nb_rd_data),
        .rd_busy(nb_rd_busy), .write_enable(write_enable), .write_reg(write_reg),
        .write_data(write_data), .muu_write_enable(muu_write_enable),
        .movn(movn), .issue_valid(issue_valid), .issue_reg(issue_reg),
        .dbg_addr(dbg_addr), .dbg_data(nb_dbg_data), .write_count(nb_write_count)
    );

    always #5 clock = ~clock;

    typedef struct {
        int          cyc;
        int          kind;
        logic [31:0] value;
        string       name;
    } exp_t;

    exp_t exp_q[$];
    int   cyc = 0;
    int   tests = 0;
    int   failures = 0;

    always @(posedge clock) cyc <= cyc + 1;

    function automatic logic [31:0] actual(input int kind);
        case (kind)
            K_RD0:   return rd_data[31:0];
            K_RD1:   return rd_data[63:32];
            K_DBG:   return dbg_data;
            K_BSY0:  return {31'd0, rd_busy[0]};
            K_BSY1:  return {31'd0, rd_busy[1]};
            K_WC:    return {16'd0, write_count};
            K_NB0:   return nb_rd_data[31:0];
            default: return 32'hXXXX_XXXX;
        endcase
    endfunction

    // Monitor: compare every expectation belonging to this cycle.
    always @(negedge clock) begin
        while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
            exp_t e;
            logic [31:0] act;
            e = exp_q.pop_front();
            tests++;
            if (e.cyc != cyc) begin
                failures++;
                $display("[TB] FAIL %s: stale expectation from cycle %0d at cycle %0d",
                         e.name, e.cyc, cyc);
            end else begin
                act = actual(e.kind);
                if (act !== e.value) begin
                    failures++;
                    $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)",
                             e.name, act, e.value, cyc);
                end
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic applyStimulus(input logic [1:0] we, input logic [AW-1:0] wreg,
                                 input logic [DW-1:0] wdata, input logic muu,
                                 input logic mv, input logic iv,
                                 input logic [AW-1:0] ireg);
        write_enable     = we;
        write_reg        = wreg;
        write_data       = wdata;
        muu_write_enable = muu;
        movn             = mv;
        issue_valid      = iv;
        issue_reg        = ireg;
    endtask

    task automatic idle();
        applyStimulus(2'b00, '0, '0, 1'b0, 1'b0, 1'b0, '0);
    endtask

    task automatic setReads(input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                            input logic [AW-1:0] d);
        rd_addr0 = a0;
        rd_addr1 = a1;
        dbg_addr = d;
    endtask

    task automatic checkOutput(input int kind, input logic [31:0] value,
                               input string name);
        exp_t e;
        e.cyc   = cyc;
        e.kind  = kind;
        e.value = value;
        e.name  = name;
        exp_q.push_back(e);
    endtask

    initial begin
        reset = 1'b1;
        idle();
        setReads(0, 0, 0);

        // Reset with a write and an issue presented: both dropped.
        step(); applyStimulus(2'b01, 3, 32'h1, 1'b0, 1'b0, 1'b1, 3);
        step();
        step(); reset = 1'b0; idle(); setReads(3, 3, 3);
        checkOutput(K_RD0, 0, "reset_rd3");
        checkOutput(K_BSY0, 0, "reset_busy3");
        checkOutput(K_DBG, 0, "reset_dbg3");
        checkOutput(K_WC, 0, "reset_wcount");

        // Plain write and readback on both ports and debug.
        step(); applyStimulus(2'b01, 8, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0, 0); setReads(0, 0, 0);
        step(); idle(); setReads(8, 8, 8);
        checkOutput(K_RD0, 32'hDEADBEEF, "wr8_rd0");
        checkOutput(K_RD1, 32'hDEADBEEF, "wr8_rd1");
        checkOutput(K_DBG, 32'hDEADBEEF, "wr8_dbg");
        checkOutput(K_WC, 1, "wr8_wcount");

        // Write to register 0, then reserved mode 11 to register 9.
        step(); applyStimulus(2'b01, 0, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, 0); setReads(0, 0, 0);
        checkOutput(K_RD0, 0, "wr0_no_bypass");
        step(); applyStimulus(2'b11, 9, 32'hAAAA5555, 1'b0, 1'b0, 1'b0, 0); setReads(0, 9, 0);
        checkOutput(K_RD0, 0, "reg0_reads0");
        checkOutput(K_WC, 1, "wr0_wcount");
        checkOutput(K_RD1, 0, "mode11_no_bypass");

        // Conditional writes to register 10.
        step(); applyStimulus(2'b10, 10, 32'd5, 1'b0, 1'b0, 1'b0, 0); setReads(9, 10, 0);
        checkOutput(K_RD0, 0, "mode11_reg9");
        checkOutput(K_WC, 1, "mode11_wcount");
        checkOutput(K_RD1, 0, "cond_none_no_bypass");
        step(); applyStimulus(2'b10, 10, 32'd7, 1'b0, 1'b1, 1'b0, 0); setReads(9, 10, 10);
        checkOutput(K_DBG, 0, "cond_none_reg10");
        checkOutput(K_RD1, 7, "cond_movn_bypass");
        step(); applyStimulus(2'b10, 10, 32'd9, 1'b1, 1'b0, 1'b0, 0); setReads(0, 10, 10);
        checkOutput(K_DBG, 7, "cond_movn_reg10");
        checkOutput(K_RD1, 9, "cond_muu_bypass");
        checkOutput(K_WC, 2, "cond_movn_wcount");
        step(); idle(); setReads(0, 10, 10);
        checkOutput(K_DBG, 9, "cond_muu_reg10");
        checkOutput(K_WC, 3, "cond_muu_wcount");

        // Bypass vs. no bypass on register 11.
        step(); applyStimulus(2'b01, 11, 32'h1234, 1'b0, 1'b0, 1'b0, 0); setReads(11, 0, 11);
        checkOutput(K_RD0, 32'h1234, "bypass_rd0");
        checkOutput(K_NB0, 0, "nobypass_rd0");
        checkOutput(K_DBG, 0, "bypass_dbg_old");
        step(); applyStimulus(2'b11, 11, 32'h5555, 1'b0, 1'b0, 1'b0, 0);
        checkOutput(K_RD0, 32'h1234, "mode11_rd11");
        checkOutput(K_NB0, 32'h1234, "nobypass_next");
        checkOutput(K_WC, 4, "bypass_wcount");
        step(); applyStimulus(2'b10, 11, 32'h6666, 1'b0, 1'b0, 1'b0, 0);
        checkOutput(K_RD0, 32'h1234, "cond_none_rd11");

        // Scoreboard: issue, then retire through a failed conditional write.
        step(); applyStimulus(2'b00, 0, 0, 1'b0, 1'b0, 1'b1, 12); setReads(12, 12, 0);
        checkOutput(K_BSY0, 0, "issue_no_busy_bypass");
        step(); applyStimulus(2'b10, 12, 32'h77, 1'b0, 1'b0, 1'b0, 0);
        checkOutput(K_BSY0, 1, "issue12_busy0");
        checkOutput(K_BSY1, 1, "issue12_busy1");
        step(); idle();
        checkOutput(K_BSY0, 0, "retire12_busy");
        checkOutput(K_RD0, 0, "retire12_value");
        checkOutput(K_WC, 4, "retire12_wcount");

        // Issue and write to register 13 in the same cycle.
        step(); applyStimulus(2'b01, 13, 32'h13, 1'b0, 1'b0, 1'b1, 13); setReads(13, 13, 0);
        step(); applyStimulus(2'b00, 0, 0, 1'b0, 1'b0, 1'b1, 0);
        checkOutput(K_BSY0, 1, "issue_wins_busy");
        checkOutput(K_RD0, 32'h13, "issue_wr13_rd0");
        checkOutput(K_RD1, 32'h13, "issue_wr13_rd1");
        checkOutput(K_WC, 5, "issue_wr13_wcount");
        step(); idle(); setReads(0, 13, 0);
        checkOutput(K_BSY0, 0, "reg0_never_busy");

        // Mid-stream reset with a write and issue on register 14.
        step(); reset = 1'b1; applyStimulus(2'b01, 14, 32'hE, 1'b0, 1'b0, 1'b1, 14);
        step(); reset = 1'b0; idle(); setReads(14, 8, 13);
        checkOutput(K_RD0, 0, "rst_reg14");
        checkOutput(K_RD1, 0, "rst_reg8");
        checkOutput(K_BSY0, 0, "rst_busy14");
        checkOutput(K_BSY1, 0, "rst_busy8");
        checkOutput(K_DBG, 0, "rst_dbg13");
        checkOutput(K_WC, 0, "rst_wcount");

        // Drive write_count to saturation.
        for (int i = 0; i < 65535; i++) begin
            step(); applyStimulus(2'b01, 1, 32'(i), 1'b0, 1'b0, 1'b0, 0);
        end
        step(); idle(); setReads(1, 0, 0);
        checkOutput(K_WC, 16'hFFFF, "sat_reach");
        checkOutput(K_RD0, 32'd65534, "sat_last_data");
        step(); applyStimulus(2'b01, 2, 32'hABCD, 1'b0, 1'b0, 1'b0, 0);
        step(); idle(); setReads(2, 0, 0);
        checkOutput(K_WC, 16'hFFFF, "sat_hold");
        checkOutput(K_RD0, 32'hABCD, "sat_write_still_commits");

        step(); step(); step();
        tests++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("[TB] FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule

// File: doc/register_bank_sb.md
Name: register_bank_sb

Overview:
Parametrised successor of the CPU register file. Provides NUM_RD combinational read ports and one write port with unconditional and conditional (multiply-unit / movn) write modes. Adds optional write-to-read bypass, a per-register busy scoreboard for multi-cycle producers, and a debug read port. Sits in the decode/writeback stage of the datapath.

Parameters:
DATA_W, 32, register width in bits
ADDR_W, 5, register address width; depth = 2**ADDR_W
NUM_RD, 2, number of read ports (1..4)
BYPASS, 1, 1 = same-cycle write data forwarded to matching read ports; 0 = reads return stored value only

Ports:
clock  in  1  system clock, all state updates on rising edge
reset  in  1  synchronous, active-high
rd_addr  in  NUM_RD*ADDR_W  read addresses; port k occupies bits [k*ADDR_W +: ADDR_W]
rd_data  out  NUM_RD*DATA_W  read data, same packing
rd_busy  out  NUM_RD  scoreboard busy bit of each addressed register
write_enable  in  2  00 off, 01 write, 10 conditional write, 11 reserved (no-op)
write_reg  in  ADDR_W  write address
write_data  in  DATA_W  write data
muu_write_enable  in  1  condition A for mode 10
movn  in  1  condition B for mode 10
issue_valid  in  1  mark issue_reg busy (multi-cycle producer dispatched)
issue_reg  in  ADDR_W  register to mark busy
dbg_addr  in  ADDR_W  debug read address
dbg_data  out  DATA_W  debug read data (never bypassed)
write_count  out  16  number of committed writes, saturating

Behaviour:
- Interface: single clock "clock"; "reset" synchronous, active-high.
- Storage: 2**ADDR_W x DATA_W registers, plus 2**ADDR_W busy bits.
- Commit condition: we_eff = (write_enable==01 || (write_enable==10 && (muu_write_enable||movn))) && write_reg!=0.
- On posedge, if we_eff: reg[write_reg] <= write_data; write_count increments, holding at 16'hFFFF.
- Register 0: always reads 0; never written; never busy.
- Reads (rd_data, dbg_data, rd_busy): combinational from current state, zero latency.
- Bypass (BYPASS=1): when we_eff and rd_addr[k]==write_reg, rd_data[k] = write_data in the same cycle. Write mode 11, or mode 10 with neither condition, is never bypassed. dbg_data is never bypassed.
- Scoreboard:
  - On posedge, if issue_valid && issue_reg!=0: busy[issue_reg] <= 1.
  - On posedge, if write_enable!=00 && write_enable!=11 && write_reg!=0: busy[write_reg] <= 0. A failed conditional write still clears busy, because the producer has retired.
  - If both target the same register in one cycle, issue wins: busy = 1.
  - rd_busy[k] reflects the registered state; there is no busy bypass.
- Reset (synchronous, takes priority over every other input in that cycle): all registers 0, all busy 0, write_count 0. A write or issue presented during reset is dropped. After reset deasserts, all outputs read 0.
- Multiple read ports may address the same register; each returns identical data.

Test Plan:
- Reset, then write_enable=01, write_reg=8, write_data=32'hDEADBEEF; next cycle rd_addr port0=8 -> rd_data0=DEADBEEF, write_count=1; debug read of reg 8 -> DEADBEEF.
- write_enable=01, write_reg=0, data=FFFFFFFF -> reg0 reads 0, write_count unchanged; write_enable=11 to reg 9 -> reg9 unchanged.
- Conditional writes, mode 10 to reg 10:
  - muu=0, movn=0, data=5 -> reg10 stays 0.
  - movn=1, data=7 -> reg10=7.
  - muu=1, data=9 -> reg10=9.
- Bypass:
  - BYPASS=1, write reg 11=32'h1234 while rd_addr0=11 -> rd_data0=1234 in the same cycle; dbg_addr=11 -> old value 0.
  - Repeat with BYPASS=0 -> rd_data0=0 until the next cycle.
- Scoreboard:
  - issue_valid, issue_reg=12 -> rd_busy=1 on reg 12 next cycle.
  - Writeback mode 10 with no condition -> busy cleared, value unchanged.
  - Simultaneous issue and write to reg 13 -> busy=1, data written.
- Assert reset mid-stream with write_enable=01, reg 14, issue_valid on reg 14 -> all regs 0, busy 0, write_count 0. Force write_count to 16'hFFFF, then perform another write -> stays FFFF.
